// File: rtl/reservation_station.sv
// Four-entry reservation station: dispatch, CDB wakeup, arbiter-driven issue.
// Optional macro RS_OCCUPANCY_EN adds the count_OUT occupancy output.
module reservation_station #(
  parameter int TAG_W = 5,
  parameter int OP_W  = 6
) (
  input  logic             clk_IN,
  input  logic             reset_n_IN,
  input  logic             flush_IN,
  input  logic             disp_valid_IN,
  input  logic [OP_W-1:0]  disp_op_IN,
  input  logic [TAG_W-1:0] disp_dest_IN,
  input  logic             disp_src1_rdy_IN,
  input  logic [TAG_W-1:0] disp_src1_tag_IN,
  input  logic [31:0]      disp_src1_val_IN,
  input  logic             disp_src2_rdy_IN,
  input  logic [TAG_W-1:0] disp_src2_tag_IN,
  input  logic [31:0]      disp_src2_val_IN,
  output logic             full_OUT,
  input  logic             cdb_valid_IN,
  input  logic [TAG_W-1:0] cdb_tag_IN,
  input  logic [31:0]      cdb_data_IN,
  output logic [3:0]       requests_OUT,
  input  logic [3:0]       grants_IN,
  output logic             issue_valid_OUT,
  output logic [OP_W-1:0]  issue_op_OUT,
  output logic [TAG_W-1:0] issue_dest_OUT,
  output logic [31:0]      issue_src1_OUT,
  output logic [31:0]      issue_src2_OUT
`ifdef RS_OCCUPANCY_EN
  ,
  output logic [2:0]       count_OUT
`endif
);

  // Handshakes: a dispatch transfers on a rising edge with disp_valid_IN=1 and
  // full_OUT=0 (full_OUT is the only back-pressure). grants_IN[i] takes effect
  // only where requests_OUT[i]=1; issue_valid_OUT is a one-cycle pulse, no ready.

  logic [3:0]       valid;
  logic [3:0]       s1_rdy;
  logic [3:0]       s2_rdy;
  logic [OP_W-1:0]  op_q   [4];
  logic [TAG_W-1:0] dest_q [4];
  logic [TAG_W-1:0] s1_tag [4];
  logic [TAG_W-1:0] s2_tag [4];
  logic [31:0]      s1_val [4];
  logic [31:0]      s2_val [4];

  logic [3:0]  free_vec;
  logic [3:0]  free_sel;
  logic [3:0]  gnt_sel;
  logic [3:0]  eff_gnt;
  logic [1:0]  gnt_idx;
  logic        disp_ok;
  logic        issue_fire;
  logic [3:0]  wake1;
  logic [3:0]  wake2;
  logic        d1_rdy;
  logic        d2_rdy;
  logic [31:0] d1_val;
  logic [31:0] d2_val;

  assign full_OUT     = &valid;
  assign requests_OUT = valid & s1_rdy & s2_rdy;

  // Lowest free slot before the edge; a slot freed by this edge's grant was
  // valid, so it can never be chosen here.
  assign free_vec = ~valid;
  assign free_sel = free_vec & (~free_vec + 4'd1);

  // Multi-bit grants are illegal; only the lowest set bit is honoured.
  assign gnt_sel    = grants_IN & (~grants_IN + 4'd1);
  assign eff_gnt    = gnt_sel & requests_OUT;
  assign issue_fire = |eff_gnt;
  assign disp_ok    = disp_valid_IN & ~full_OUT;

  always_comb begin
    gnt_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eff_gnt[i]) gnt_idx = 2'(i);
    end
  end

  always_comb begin
    wake1 = 4'd0;
    wake2 = 4'd0;
    for (int i = 0; i < 4; i++) begin
      wake1[i] = cdb_valid_IN & valid[i] & ~s1_rdy[i] & (s1_tag[i] == cdb_tag_IN);
      wake2[i] = cdb_valid_IN & valid[i] & ~s2_rdy[i] & (s2_tag[i] == cdb_tag_IN);
    end
  end

  // A source dispatched not-ready can still catch a broadcast on the same edge.
  assign d1_rdy = disp_src1_rdy_IN | (cdb_valid_IN & (cdb_tag_IN == disp_src1_tag_IN));
  assign d2_rdy = disp_src2_rdy_IN | (cdb_valid_IN & (cdb_tag_IN == disp_src2_tag_IN));
  assign d1_val = disp_src1_rdy_IN ? disp_src1_val_IN : cdb_data_IN;
  assign d2_val = disp_src2_rdy_IN ? disp_src2_val_IN : cdb_data_IN;

  always_ff @(posedge clk_IN or negedge reset_n_IN) begin
    if (!reset_n_IN) begin
      valid           <= 4'd0;
      s1_rdy          <= 4'd0;
      s2_rdy          <= 4'd0;
      issue_valid_OUT <= 1'b0;
    end else if (flush_IN) begin
      valid           <= 4'd0;
      issue_valid_OUT <= 1'b0;
    end else begin
      s1_rdy <= s1_rdy | wake1;
      s2_rdy <= s2_rdy | wake2;
      for (int i = 0; i < 4; i++) begin
        if (eff_gnt[i]) valid[i] <= 1'b0;
        if (disp_ok && free_sel[i]) begin
          valid[i]  <= 1'b1;
          s1_rdy[i] <= d1_rdy;
          s2_rdy[i] <= d2_rdy;
        end
      end
      issue_valid_OUT <= issue_fire;
    end
  end

  // Payload carries no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk_IN) begin
    if (!flush_IN) begin
      for (int i = 0; i < 4; i++) begin
        if (wake1[i]) s1_val[i] <= cdb_data_IN;
        if (wake2[i]) s2_val[i] <= cdb_data_IN;
        if (disp_ok && free_sel[i]) begin
          op_q[i]   <= disp_op_IN;
          dest_q[i] <= disp_dest_IN;
          s1_tag[i] <= disp_src1_tag_IN;
          s2_tag[i] <= disp_src2_tag_IN;
          s1_val[i] <= d1_val;
          s2_val[i] <= d2_val;
        end
      end
      if (issue_fire) begin
        issue_op_OUT   <= op_q[gnt_idx];
        issue_dest_OUT <= dest_q[gnt_idx];
        issue_src1_OUT <= s1_val[gnt_idx];
        issue_src2_OUT <= s2_val[gnt_idx];
      end
    end
  end

`ifdef RS_OCCUPANCY_EN
  assign count_OUT = {2'd0, valid[0]} + {2'd0, valid[1]} + {2'd0, valid[2]} + {2'd0, valid[3]};
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table plus issue-packet scoreboard,
// followed by an asynchronous-reset sequence.
module tb_reservation_station;

  logic        clk_IN = 1'b0;
  logic        reset_n_IN;
  logic        flush_IN;
  logic        disp_valid_IN;
  logic [5:0]  disp_op_IN;
  logic [4:0]  disp_dest_IN;
  logic        disp_src1_rdy_IN;
  logic [4:0]  disp_src1_tag_IN;
  logic [31:0] disp_src1_val_IN;
  logic        disp_src2_rdy_IN;
  logic [4:0]  disp_src2_tag_IN;
  logic [31:0] disp_src2_val_IN;
  logic        full_OUT;
  logic        cdb_valid_IN;
  logic [4:0]  cdb_tag_IN;
  logic [31:0] cdb_data_IN;
  logic [3:0]  requests_OUT;
  logic [3:0]  grants_IN;
  logic        issue_valid_OUT;
  logic [5:0]  issue_op_OUT;
  logic [4:0]  issue_dest_OUT;
  logic [31:0] issue_src1_OUT;
  logic [31:0] issue_src2_OUT;
`ifdef RS_OCCUPANCY_EN
  logic [2:0]  count_OUT;
`endif

  always #5 clk_IN = ~clk_IN;

  reservation_station #(.TAG_W(5), .OP_W(6)) dut (
    .clk_IN(clk_IN), .reset_n_IN(reset_n_IN), .flush_IN(flush_IN),
    .disp_valid_IN(disp_valid_IN), .disp_op_IN(disp_op_IN), .disp_dest_IN(disp_dest_IN),
    .disp_src1_rdy_IN(disp_src1_rdy_IN), .disp_src1_tag_IN(disp_src1_tag_IN),
    .disp_src1_val_IN(disp_src1_val_IN), .disp_src2_rdy_IN(disp_src2_rdy_IN),
    .disp_src2_tag_IN(disp_src2_tag_IN), .disp_src2_val_IN(disp_src2_val_IN),
    .full_OUT(full_OUT), .cdb_valid_IN(cdb_valid_IN), .cdb_tag_IN(cdb_tag_IN),
    .cdb_data_IN(cdb_data_IN), .requests_OUT(requests_OUT), .grants_IN(grants_IN),
    .issue_valid_OUT(issue_valid_OUT), .issue_op_OUT(issue_op_OUT),
    .issue_dest_OUT(issue_dest_OUT), .issue_src1_OUT(issue_src1_OUT),
    .issue_src2_OUT(issue_src2_OUT)
`ifdef RS_OCCUPANCY_EN
    , .count_OUT(count_OUT)
`endif
  );

  typedef struct {
    logic        flush;
    logic        dv;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic        r1;
    logic [4:0]  t1;
    logic [31:0] v1;
    logic        r2;
    logic [4:0]  t2;
    logic [31:0] v2;
    logic        cv;
    logic [4:0]  ct;
    logic [31:0] cd;
    logic [3:0]  gnt;
    logic [3:0]  exp_req;
    logic        exp_full;
    logic [2:0]  exp_cnt;
    logic        exp_iv;
    logic [74:0] exp_pkt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [74:0] exp_q[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [74:0] pk(input logic [5:0] op, input logic [4:0] dest,
                                     input logic [31:0] s1, input logic [31:0] s2);
    return {op, dest, s1, s2};
  endfunction

  function automatic vec_t nop();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t vd(input logic [5:0] op, input logic [4:0] dest,
                              input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                              input logic r2, input logic [4:0] t2, input logic [31:0] v2);
    vec_t v;
    v = nop();
    v.dv = 1'b1; v.op = op; v.dest = dest;
    v.r1 = r1; v.t1 = t1; v.v1 = v1;
    v.r2 = r2; v.t2 = t2; v.v2 = v2;
    return v;
  endfunction

  function automatic vec_t gn(input vec_t vi, input logic [3:0] g);
    vec_t v;
    v = vi; v.gnt = g;
    return v;
  endfunction

  function automatic vec_t cb(input vec_t vi, input logic [4:0] t, input logic [31:0] d);
    vec_t v;
    v = vi; v.cv = 1'b1; v.ct = t; v.cd = d;
    return v;
  endfunction

  function automatic vec_t fl(input vec_t vi);
    vec_t v;
    v = vi; v.flush = 1'b1;
    return v;
  endfunction

  function automatic vec_t iss(input vec_t vi, input logic [74:0] pkt);
    vec_t v;
    v = vi; v.exp_iv = 1'b1; v.exp_pkt = pkt;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic [3:0] req, input logic full,
                              input logic [2:0] cnt);
    vec_t v;
    v = vi; v.exp_req = req; v.exp_full = full; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic idle_inputs();
    flush_IN = 0; disp_valid_IN = 0; disp_op_IN = '0; disp_dest_IN = '0;
    disp_src1_rdy_IN = 0; disp_src1_tag_IN = '0; disp_src1_val_IN = '0;
    disp_src2_rdy_IN = 0; disp_src2_tag_IN = '0; disp_src2_val_IN = '0;
    cdb_valid_IN = 0; cdb_tag_IN = '0; cdb_data_IN = '0; grants_IN = '0;
  endtask

  // Called at a falling edge; drives one vector across one rising edge.
  task automatic apply(input vec_t v, input int idx);
    flush_IN = v.flush; disp_valid_IN = v.dv; disp_op_IN = v.op; disp_dest_IN = v.dest;
    disp_src1_rdy_IN = v.r1; disp_src1_tag_IN = v.t1; disp_src1_val_IN = v.v1;
    disp_src2_rdy_IN = v.r2; disp_src2_tag_IN = v.t2; disp_src2_val_IN = v.v2;
    cdb_valid_IN = v.cv; cdb_tag_IN = v.ct; cdb_data_IN = v.cd; grants_IN = v.gnt;
    if (v.exp_iv) exp_q.push_back(v.exp_pkt);
    @(posedge clk_IN);
    #1;
    check($sformatf("v%0d requests", idx), 75'(requests_OUT), 75'(v.exp_req));
    check($sformatf("v%0d full", idx), 75'(full_OUT), 75'(v.exp_full));
    check($sformatf("v%0d issue_valid", idx), 75'(issue_valid_OUT), 75'(v.exp_iv));
`ifdef RS_OCCUPANCY_EN
    check($sformatf("v%0d count", idx), 75'(count_OUT), 75'(v.exp_cnt));
`endif
    if (issue_valid_OUT) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL v%0d unexpected_issue actual=%0h required=none", idx,
                 {issue_op_OUT, issue_dest_OUT, issue_src1_OUT, issue_src2_OUT});
      end else begin
        check($sformatf("v%0d issue_packet", idx),
              {issue_op_OUT, issue_dest_OUT, issue_src1_OUT, issue_src2_OUT},
              exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    @(negedge clk_IN);
  endtask

  initial begin
    reset_n_IN = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_IN);
    check("reset requests", 75'(requests_OUT), 75'd0);
    check("reset full", 75'(full_OUT), 75'd0);
    check("reset issue_valid", 75'(issue_valid_OUT), 75'd0);
    reset_n_IN = 1'b1;

    // Basic issue, then CDB wakeup of src2.
    tbl.push_back(ex(vd(6'h08, 5'd3, 1, 0, 32'd5, 1, 0, 32'd7), 4'b0001, 0, 3'd1));
    tbl.push_back(ex(iss(gn(nop(), 4'b0001), pk(6'h08, 5'd3, 32'd5, 32'd7)), 4'b0000, 0, 3'd0));
    tbl.push_back(ex(vd(6'h01, 5'd4, 1, 0, 32'h10, 0, 5'd9, 32'd0), 4'b0000, 0, 3'd1));
    tbl.push_back(ex(cb(nop(), 5'd9, 32'hDEADBEEF), 4'b0001, 0, 3'd1));
    tbl.push_back(ex(iss(gn(nop(), 4'b0001), pk(6'h01, 5'd4, 32'h10, 32'hDEADBEEF)), 4'b0000, 0, 3'd0));
    // Dispatch catching a same-edge broadcast.
    tbl.push_back(ex(cb(vd(6'h02, 5'd5, 0, 5'd4, 32'd0, 1, 0, 32'h22), 5'd4, 32'h11), 4'b0001, 0, 3'd1));
    tbl.push_back(ex(iss(gn(nop(), 4'b0001), pk(6'h02, 5'd5, 32'h11, 32'h22)), 4'b0000, 0, 3'd0));
    // Fill, drop when full, grant with same-edge dispatch dropped, refill slot 2.
    tbl.push_back(ex(vd(6'h10, 5'd10, 1, 0, 32'h100, 1, 0, 32'h200), 4'b0001, 0, 3'd1));
    tbl.push_back(ex(vd(6'h11, 5'd11, 1, 0, 32'h101, 1, 0, 32'h201), 4'b0011, 0, 3'd2));
    tbl.push_back(ex(vd(6'h12, 5'd12, 1, 0, 32'h102, 1, 0, 32'h202), 4'b0111, 0, 3'd3));
    tbl.push_back(ex(vd(6'h13, 5'd13, 1, 0, 32'h103, 1, 0, 32'h203), 4'b1111, 1, 3'd4));
    tbl.push_back(ex(vd(6'h14, 5'd14, 1, 0, 32'h104, 1, 0, 32'h204), 4'b1111, 1, 3'd4));
    tbl.push_back(ex(iss(gn(vd(6'h15, 5'd15, 1, 0, 32'h300, 1, 0, 32'h301), 4'b0100),
                         pk(6'h12, 5'd12, 32'h102, 32'h202)), 4'b1011, 0, 3'd3));
    tbl.push_back(ex(vd(6'h16, 5'd16, 1, 0, 32'h400, 1, 0, 32'h401), 4'b1111, 1, 3'd4));
    tbl.push_back(ex(iss(gn(nop(), 4'b0100), pk(6'h16, 5'd16, 32'h400, 32'h401)), 4'b1011, 0, 3'd3));
    // Multi-bit grant honours the lowest bit; grants to idle or waiting entries ignored.
    tbl.push_back(ex(iss(gn(nop(), 4'b1010), pk(6'h11, 5'd11, 32'h101, 32'h201)), 4'b1001, 0, 3'd2));
    tbl.push_back(ex(gn(nop(), 4'b0010), 4'b1001, 0, 3'd2));
    tbl.push_back(ex(vd(6'h17, 5'd17, 0, 5'd20, 32'd0, 1, 0, 32'h66), 4'b1001, 0, 3'd3));
    tbl.push_back(ex(gn(nop(), 4'b0010), 4'b1001, 0, 3'd3));
    tbl.push_back(ex(cb(nop(), 5'd20, 32'h55), 4'b1011, 0, 3'd3));
    // Flush discards grant, dispatch and wakeup on its edge.
    tbl.push_back(ex(fl(cb(gn(vd(6'h30, 5'd30, 1, 0, 32'd1, 1, 0, 32'd1), 4'b0010), 5'd1, 32'd9)),
                     4'b0000, 0, 3'd0));
    tbl.push_back(ex(vd(6'h18, 5'd18, 1, 0, 32'd1, 1, 0, 32'd2), 4'b0001, 0, 3'd1));
    // Ready src1 with matching tag must keep its value; waiting src2 wakes.
    tbl.push_back(ex(vd(6'h19, 5'd19, 1, 5'd7, 32'hAA, 0, 5'd7, 32'd0), 4'b0001, 0, 3'd2));
    tbl.push_back(ex(iss(cb(gn(nop(), 4'b0001), 5'd7, 32'h77), pk(6'h18, 5'd18, 32'd1, 32'd2)),
                     4'b0010, 0, 3'd1));
    tbl.push_back(ex(iss(gn(nop(), 4'b0010), pk(6'h19, 5'd19, 32'hAA, 32'h77)), 4'b0000, 0, 3'd0));

    @(negedge clk_IN);
    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset pulse between edges with three valid entries.
    for (int i = 0; i < 4; i++) begin
      apply(ex(vd(6'h20 + 6'(i), 5'd20 + 5'(i), 1, 0, 32'h1000 + 32'(i), 1, 0, 32'h2000 + 32'(i)),
               4'((1 << (i + 1)) - 1), (i == 3), 3'(i + 1)), 100 + i);
    end
    apply(ex(iss(gn(nop(), 4'b0001), pk(6'h20, 5'd20, 32'h1000, 32'h2000)), 4'b1110, 0, 3'd3), 104);
`ifdef RS_OCCUPANCY_EN
    check("pre_reset count", 75'(count_OUT), 75'd3);
`endif
    #2 reset_n_IN = 1'b0;
    #1;
    check("async_reset requests", 75'(requests_OUT), 75'd0);
    check("async_reset full", 75'(full_OUT), 75'd0);
    check("async_reset issue_valid", 75'(issue_valid_OUT), 75'd0);
`ifdef RS_OCCUPANCY_EN
    check("async_reset count", 75'(count_OUT), 75'd0);
`endif
    #1 reset_n_IN = 1'b1;
    apply(ex(vd(6'h28, 5'd28, 1, 0, 32'd3, 1, 0, 32'd4), 4'b0001, 0, 3'd1), 105);
    apply(ex(iss(gn(nop(), 4'b0001), pk(6'h28, 5'd28, 32'd3, 32'd4)), 4'b0000, 0, 3'd0), 106);

    check("scoreboard drained", 75'(exp_q.size()), 75'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
